// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multicycle RV32I-style datapath. It sequences each
// instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). It drives the
// memory, instruction-register, immediate, PC and register-file strobes. It
// also counts retired instructions.
//
// Ports
//   clk           : clock, all state updates on the rising edge
//   rst           : asynchronous active-high reset
//   instr[31:0]   : instruction register contents (opcode and rd are decoded)
//   mem_ready     : memory accepts or returns data this cycle
//   branch_taken  : ALU branch-compare result, valid in EXEC
//   mem_req       : memory request
//   mem_we        : memory write (store)
//   mem_sel_data  : address select, 0 = PC, 1 = ALU result
//   ir_we         : instruction register load
//   imm_we        : immediate register load
//   pc_we         : PC load
//   pc_src[1:0]   : 0 = PC+4, 1 = PC+imm, 2 = ALU result
//   rf_we         : register-file write
//   wb_sel[1:0]   : 0 = ALU, 1 = memory data, 2 = PC+4
//   illegal       : sticky illegal-opcode flag (set while in TRAP)
//   state[2:0]    : current FSM state
//   instret[31:0] : retired-instruction counter
// ----------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel_data,
    output logic        ir_we,
    output logic        imm_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] instret_q;
    logic        retire;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic        legal;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];

    // Only the opcode and rd fields steer control; the rest of the word feeds
    // the immediate extender and register file outside this block.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[31:12];

    always_comb begin
        unique case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: legal = 1'b1;
            default:                          legal = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement or process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Wraps naturally from 0xFFFFFFFF to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_data = 1'b0;
        ir_we        = 1'b0;
        imm_we       = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        illegal      = 1'b0;
        retire       = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end
            end

            DECODE: begin
                imm_we  = 1'b1;
                state_d = legal ? EXEC : TRAP;
            end

            EXEC: begin
                if (opcode == OP_BRANCH) begin
                    pc_we   = 1'b1;
                    pc_src  = branch_taken ? 2'd1 : 2'd0;
                    retire  = 1'b1;
                    state_d = FETCH;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end

            MEM: begin
                mem_req      = 1'b1;
                mem_sel_data = 1'b1;
                mem_we       = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end

            WB: begin
                rf_we   = (rd != 5'd0);
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
                if (opcode == OP_LOAD) begin
                    wb_sel = 2'd1;
                end else if (opcode == OP_JAL || opcode == OP_JALR) begin
                    wb_sel = 2'd2;
                end
                if (opcode == OP_JAL) begin
                    pc_src = 2'd1;
                end else if (opcode == OP_JALR) begin
                    pc_src = 2'd2;
                end
            end

            TRAP: begin
                illegal = 1'b1;
                state_d = TRAP;
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        // The state register resets asynchronously to FETCH, which would
        // otherwise raise mem_req while rst is still high. Masking here keeps
        // the request and all write enables low for the whole reset window,
        // including a reset that lands mid-FETCH or mid-MEM.
        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_sel_data = 1'b0;
            ir_we        = 1'b0;
            imm_we       = 1'b0;
            pc_we        = 1'b0;
            pc_src       = 2'd0;
            rf_we        = 1'b0;
            wb_sel       = 2'd0;
            illegal      = 1'b0;
            retire       = 1'b0;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Scoreboard bench for multicycle_ctrl. The stimulus process drives one cycle
// at a time and pushes the hand-derived output snapshot for that cycle. A
// separate monitor pops and compares on every falling edge.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0]  st;
        logic        req;
        logic        we;
        logic        sel;
        logic        ir;
        logic        imm;
        logic        pcw;
        logic [1:0]  pcs;
        logic        rfw;
        logic [1:0]  wbs;
        logic        ill;
        logic [31:0] ret;
    } snap_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_we;
    logic        mem_sel_data;
    logic        ir_we;
    logic        imm_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] instret;

    snap_t       sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_cyc  = 0;
    logic [31:0] ret;

    multicycle_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_sel_data (mem_sel_data),
        .ir_we        (ir_we),
        .imm_we       (imm_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .illegal      (illegal),
        .state        (state),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic snap_t mk(input logic [2:0] st, input logic req, input logic we,
                                 input logic sel, input logic ir, input logic imm,
                                 input logic pcw, input logic [1:0] pcs, input logic rfw,
                                 input logic [1:0] wbs, input logic ill, input logic [31:0] r);
        snap_t s;
        s = '{st: st, req: req, we: we, sel: sel, ir: ir, imm: imm, pcw: pcw,
              pcs: pcs, rfw: rfw, wbs: wbs, ill: ill, ret: r};
        return s;
    endfunction

    // Monitor: compares whatever the DUT presents against the oldest entry.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            snap_t e;
            snap_t a;
            e = sb.pop_front();
            a = '{st: state, req: mem_req, we: mem_we, sel: mem_sel_data, ir: ir_we,
                  imm: imm_we, pcw: pc_we, pcs: pc_src, rfw: rf_we, wbs: wb_sel,
                  ill: illegal, ret: instret};
            n_cyc++;
            check($sformatf("cycle %0d state=%0d", n_cyc, e.st), 64'(a), 64'(e));
        end
    end

    // One clock of stimulus: drive inputs, queue the expected snapshot, advance.
    task automatic step(input logic rdy, input logic bt, input snap_t e);
        mem_ready    = rdy;
        branch_taken = bt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic c_rst();
        step(1'b1, 1'b1, mk(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 32'd0));
    endtask
    task automatic c_fetch(input logic rdy);
        step(rdy, 1'b0, mk(3'd0, 1, 0, 0, rdy, 0, 0, 2'd0, 0, 2'd0, 0, ret));
    endtask
    task automatic c_decode();
        step(1'b1, 1'b1, mk(3'd1, 0, 0, 0, 0, 1, 0, 2'd0, 0, 2'd0, 0, ret));
    endtask
    task automatic c_exec(input logic bt, input logic pcw, input logic [1:0] pcs);
        step(1'b1, bt, mk(3'd2, 0, 0, 0, 0, 0, pcw, pcs, 0, 2'd0, 0, ret));
    endtask
    task automatic c_mem(input logic rdy, input logic we, input logic pcw);
        step(rdy, 1'b0, mk(3'd3, 1, we, 1, 0, 0, pcw, 2'd0, 0, 2'd0, 0, ret));
    endtask
    task automatic c_wb(input logic rfw, input logic [1:0] wbs, input logic [1:0] pcs);
        step(1'b1, 1'b0, mk(3'd4, 0, 0, 0, 0, 0, 1, pcs, rfw, wbs, 0, ret));
    endtask
    task automatic c_trap(input logic rdy);
        step(rdy, rdy, mk(3'd7, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, ret));
    endtask

    initial begin
        rst          = 1'b1;
        instr        = 32'h0000_0013;
        mem_ready    = 1'b1;
        branch_taken = 1'b0;
        ret          = 32'd0;
        @(posedge clk);
        #1;
        c_rst();
        c_rst();
        rst = 1'b0;

        // ADDI x1, x0, 5: 0,1,2,4 then FETCH with instret=1.
        instr = 32'h0050_0093;
        c_fetch(1); c_decode(); c_exec(0, 0, 2'd0); c_wb(1, 2'd0, 2'd0); ret++;

        // LW x2, 0(x1) with three MEM wait cycles: 8 cycles total.
        instr = 32'h0000_A103;
        c_fetch(1); c_decode(); c_exec(0, 0, 2'd0);
        c_mem(0, 0, 0); c_mem(0, 0, 0); c_mem(0, 0, 0); c_mem(1, 0, 0);
        c_wb(1, 2'd1, 2'd0); ret++;

        // BEQ taken, with one fetch stall; retires in EXEC, no WB.
        instr = 32'h0000_0463;
        c_fetch(0); c_fetch(1); c_decode(); c_exec(1, 1, 2'd1); ret++;

        // BEQ not taken.
        c_fetch(1); c_decode(); c_exec(0, 1, 2'd0); ret++;

        // JALR x1, 0(x2).
        instr = 32'h0001_00E7;
        c_fetch(1); c_decode(); c_exec(0, 0, 2'd0); c_wb(1, 2'd2, 2'd2); ret++;

        // JALR x0, 0(x2): no register write.
        instr = 32'h0001_0067;
        c_fetch(1); c_decode(); c_exec(0, 0, 2'd0); c_wb(0, 2'd2, 2'd2); ret++;

        // JAL x1, 8.
        instr = 32'h0080_00EF;
        c_fetch(1); c_decode(); c_exec(0, 0, 2'd0); c_wb(1, 2'd2, 2'd1); ret++;

        // SW x2, 0(x1) with one MEM wait cycle; retires in MEM.
        instr = 32'h0020_A023;
        c_fetch(1); c_decode(); c_exec(0, 0, 2'd0); c_mem(0, 1, 0); c_mem(1, 1, 1); ret++;

        // LUI x3, 1.
        instr = 32'h0000_11B7;
        c_fetch(1); c_decode(); c_exec(0, 0, 2'd0); c_wb(1, 2'd0, 2'd0); ret++;

        // Counter wrap: preload 0xFFFFFFFF, retire one ADDI.
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        ret   = 32'hFFFF_FFFF;
        instr = 32'h0050_0093;
        c_fetch(1); c_decode(); c_exec(0, 0, 2'd0); c_wb(1, 2'd0, 2'd0); ret = ret + 32'd1;
        check("instret wrap expectation", 64'(ret), 64'd0);

        // Reset lands mid-MEM of a store: request and write drop at once.
        instr = 32'h0020_A023;
        c_fetch(1); c_decode(); c_exec(0, 0, 2'd0); c_mem(0, 1, 0);
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("mid-MEM reset mem_req", 64'(mem_req), 64'd0);
        check("mid-MEM reset mem_we", 64'(mem_we), 64'd0);
        check("mid-MEM reset state", 64'(state), 64'd0);
        ret = 32'd0;
        c_rst();
        rst = 1'b0;
        c_fetch(0);

        // Illegal opcode: TRAP after DECODE, held, instret unchanged.
        instr = 32'h0000_007F;
        c_fetch(1); c_decode();
        for (int i = 0; i < 12; i++) begin
            c_trap(1'(i % 2));
        end
        rst = 1'b1;
        #1;
        check("trap reset illegal", 64'(illegal), 64'd0);
        check("trap reset state", 64'(state), 64'd0);
        c_rst();
        rst = 1'b0;
        instr = 32'h0050_0093;
        c_fetch(1);

        @(negedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
